// File: rtl/clock_seq_pkg.sv
// rtl/clock_seq_pkg.sv - shared op-codes and state types for the clock burst sequencer
package clock_seq_pkg;

  localparam logic [1:0] OP_STOP  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_BURST = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    CMD_STOP  = OP_STOP,
    CMD_RUN   = OP_RUN,
    CMD_BURST = OP_BURST,
    CMD_RSVD  = OP_RSVD
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST,
    ST_STOPPING
  } seq_state_e;

endpackage

// File: rtl/clock_burst_sequencer_if.sv
// rtl/clock_burst_sequencer_if.sv - config/command handshakes and divided-clock outputs
interface clock_burst_sequencer_if #(
  parameter int REGISTER_WIDTH = 8,
  parameter int BURST_WIDTH    = 16
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [REGISTER_WIDTH-1:0] cfg_up;
  logic [REGISTER_WIDTH-1:0] cfg_down;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [BURST_WIDTH-1:0]    cmd_count;
  logic                      clk_out;
  logic                      busy;
  logic                      done;

  modport master (
    output cfg_valid, cfg_up, cfg_down, cmd_valid, cmd_op, cmd_count,
    input  cfg_ready, cmd_ready, clk_out, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_up, cfg_down, cmd_valid, cmd_op, cmd_count,
    output cfg_ready, cmd_ready, clk_out, busy, done
  );
endinterface

// File: rtl/clock_phase_counter.sv
// rtl/clock_phase_counter.sv - phase counter and registered clk_out; every high phase is started by load_start
module clock_phase_counter #(
  parameter int REGISTER_WIDTH = 8
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load_start,
  input  logic [REGISTER_WIDTH-1:0] up_len,
  input  logic [REGISTER_WIDTH-1:0] down_len,
  output logic                      clk_out,
  output logic                      rise_strobe,
  output logic                      fall_end_strobe
);
  logic [REGISTER_WIDTH-1:0] cnt_q;
  logic                      at_limit;

  assign at_limit        = cnt_q >= (clk_out ? up_len : down_len);
  assign fall_end_strobe = enable && !clk_out && at_limit;
  assign rise_strobe     = load_start;

  // A finished low phase holds until the controller decides whether another high follows.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      clk_out <= 1'b0;
      cnt_q   <= REGISTER_WIDTH'(1);
    end else if (load_start) begin
      clk_out <= 1'b1;
      cnt_q   <= REGISTER_WIDTH'(1);
    end else if (!enable) begin
      clk_out <= 1'b0;
      cnt_q   <= REGISTER_WIDTH'(1);
    end else if (at_limit) begin
      if (clk_out) begin
        clk_out <= 1'b0;
        cnt_q   <= REGISTER_WIDTH'(1);
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/clock_burst_sequencer.sv
// rtl/clock_burst_sequencer.sv - run/burst/stop sequencing of a glitch-free divided clock
module clock_burst_sequencer
  import clock_seq_pkg::*;
#(
  parameter int REGISTER_WIDTH = 8,
  parameter int BURST_WIDTH    = 16,
  parameter int DEFAULT_UP     = 2,
  parameter int DEFAULT_DOWN   = 2
) (
  input  logic                  clk_in,
  input  logic                  reset,
  clock_burst_sequencer_if.slave bus
);
  seq_state_e                state_q, state_d;
  logic [BURST_WIDTH-1:0]    remaining_q, remaining_d;
  logic                      skip_q, skip_d;
  logic                      done_q, done_d;
  logic [REGISTER_WIDTH-1:0] active_up, active_down, shadow_up, shadow_down;
  logic [REGISTER_WIDTH-1:0] cfg_up_c, cfg_down_c;
  logic                      shadow_full;
  logic                      cfg_fire, cmd_fire, load_start, rise, fall_end;
  cmd_op_e                   op;

  assign op            = cmd_op_e'(bus.cmd_op);
  assign bus.cfg_ready = !shadow_full;
  assign bus.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign cfg_up_c      = (bus.cfg_up == '0) ? REGISTER_WIDTH'(1) : bus.cfg_up;
  assign cfg_down_c    = (bus.cfg_down == '0) ? REGISTER_WIDTH'(1) : bus.cfg_down;

  clock_phase_counter #(.REGISTER_WIDTH(REGISTER_WIDTH)) u_phase (
    .clk_in          (clk_in),
    .reset           (reset),
    .enable          (state_q != ST_IDLE),
    .load_start      (load_start),
    .up_len          (active_up),
    .down_len        (active_down),
    .clk_out         (bus.clk_out),
    .rise_strobe     (rise),
    .fall_end_strobe (fall_end)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    skip_d      = skip_q;
    done_d      = 1'b0;
    load_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (op == CMD_RUN) begin
            state_d    = ST_RUN;
            load_start = 1'b1;
          end else if (op == CMD_BURST) begin
            if (bus.cmd_count != '0) begin
              state_d     = ST_BURST;
              remaining_d = bus.cmd_count;
              skip_d      = 1'b0;
              load_start  = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        load_start = fall_end;
        // A period already in flight is not one of the burst's pulses, unless it starts on this edge.
        if (cmd_fire) begin
          if (op == CMD_STOP || (op == CMD_BURST && bus.cmd_count == '0)) begin
            state_d = ST_STOPPING;
          end else if (op == CMD_BURST) begin
            state_d     = ST_BURST;
            remaining_d = bus.cmd_count;
            skip_d      = !fall_end;
          end
        end
      end
      ST_BURST: begin
        if (fall_end) begin
          if (skip_q) begin
            skip_d     = 1'b0;
            load_start = 1'b1;
          end else if (remaining_q <= BURST_WIDTH'(1)) begin
            remaining_d = '0;
            state_d     = ST_IDLE;
            done_d      = 1'b1;
          end else begin
            remaining_d = remaining_q - 1'b1;
            load_start  = 1'b1;
          end
        end
      end
      ST_STOPPING: begin
        if (fall_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      skip_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      skip_q      <= skip_d;
      done_q      <= done_d;
    end
  end

  // Shadow lands on a rising edge so the new high phase is counted against the new length.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      active_up   <= REGISTER_WIDTH'(DEFAULT_UP);
      active_down <= REGISTER_WIDTH'(DEFAULT_DOWN);
      shadow_up   <= '0;
      shadow_down <= '0;
      shadow_full <= 1'b0;
    end else begin
      if (shadow_full && (rise || state_q == ST_IDLE)) begin
        active_up   <= shadow_up;
        active_down <= shadow_down;
        shadow_full <= 1'b0;
      end
      if (cfg_fire) begin
        if (state_q == ST_IDLE) begin
          active_up   <= cfg_up_c;
          active_down <= cfg_down_c;
        end else begin
          shadow_up   <= cfg_up_c;
          shadow_down <= cfg_down_c;
          shadow_full <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_clock_burst_sequencer.sv
// tb/tb_clock_burst_sequencer.sv - randomized check of the sequencer against a phase-level reference model
module tb_clock_burst_sequencer;
  localparam int RW = 8;
  localparam int BW = 16;
  localparam int DU = 2;
  localparam int DD = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_BURST = 2, M_STOP = 3;

  logic clk_in;
  logic reset;
  int   n_cmp, n_err, cyc;

  // reference: mode, current level, cycles left in the phase, highs still owed by a burst
  int m_mode, m_left, m_up, m_down, m_pup, m_pdown, m_owed;
  bit m_lvl, m_pend, m_done;

  clock_burst_sequencer_if #(.REGISTER_WIDTH(RW), .BURST_WIDTH(BW)) bus ();

  clock_burst_sequencer #(
    .REGISTER_WIDTH(RW), .BURST_WIDTH(BW), .DEFAULT_UP(DU), .DEFAULT_DOWN(DD)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_lvl = 0; m_left = 0; m_up = DU; m_down = DD;
    m_pend = 0; m_pup = 0; m_pdown = 0; m_owed = 0; m_done = 0;
  endtask

  task automatic model_step(input bit cv, input int up, input int dn,
                            input bit mv, input int op, input int cnt);
    int mode0;
    bit rise, cfg_x, cmd_x;
    mode0  = m_mode;
    rise   = 0;
    cfg_x  = cv && !m_pend;
    cmd_x  = mv && (mode0 == M_IDLE || mode0 == M_RUN);
    m_done = 0;
    if (mode0 != M_IDLE) begin
      if (m_left > 1) m_left--;
      else if (m_lvl) begin m_lvl = 0; m_left = m_down; end
      else if (mode0 == M_RUN) rise = 1;
      else if (mode0 == M_BURST && m_owed > 0) begin m_owed--; rise = 1; end
      else begin m_mode = M_IDLE; m_done = 1; end
    end
    if (cmd_x) begin
      if (mode0 == M_IDLE) begin
        if (op == 1) begin m_mode = M_RUN; rise = 1; end
        else if (op == 2) begin
          if (cnt > 0) begin m_mode = M_BURST; m_owed = cnt - 1; rise = 1; end
          else m_done = 1;
        end
      end else begin
        if (op == 0 || (op == 2 && cnt == 0)) m_mode = M_STOP;
        else if (op == 2) begin m_mode = M_BURST; m_owed = rise ? cnt - 1 : cnt; end
      end
    end
    if (m_pend && (rise || mode0 == M_IDLE)) begin
      m_up = m_pup; m_down = m_pdown; m_pend = 0;
    end
    if (cfg_x) begin
      if (mode0 == M_IDLE) begin m_up = clamp(up); m_down = clamp(dn); end
      else begin m_pend = 1; m_pup = clamp(up); m_pdown = clamp(dn); end
    end
    if (rise) begin m_lvl = 1; m_left = m_up; end
  endtask

  task automatic compare_all();
    check("clk_out",   bus.clk_out,   m_lvl);
    check("busy",      bus.busy,      m_mode != M_IDLE);
    check("done",      bus.done,      m_done);
    check("cfg_ready", bus.cfg_ready, !m_pend);
    check("cmd_ready", bus.cmd_ready, m_mode == M_IDLE || m_mode == M_RUN);
  endtask

  task automatic step(input bit cv, input int up, input int dn,
                      input bit mv, input int op, input int cnt);
    bus.cfg_valid = cv;  bus.cfg_up = up[RW-1:0]; bus.cfg_down = dn[RW-1:0];
    bus.cmd_valid = mv;  bus.cmd_op = op[1:0];    bus.cmd_count = cnt[BW-1:0];
    model_step(cv, up, dn, mv, op, cnt);
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.cfg_valid = 0; bus.cfg_up = '0; bus.cfg_down = '0;
    bus.cmd_valid = 0; bus.cmd_op = '0; bus.cmd_count = '0;
    model_reset();
    repeat (n) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    cyc = 0;
    compare_all();
  endtask

  initial begin
    int  rises, done_cyc, done_n;
    bit  prev;
    n_cmp = 0; n_err = 0; cyc = 0;
    do_reset(3);

    // free run at defaults
    step(0, 0, 0, 1, 1, 0);
    idle(9);

    // two-pulse burst from idle
    do_reset(1);
    prev = 0; rises = 0; done_cyc = -1; done_n = 0;
    step(0, 0, 0, 1, 2, 2);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) idle(1);
      if (bus.clk_out && !prev) rises++;
      prev = bus.clk_out;
      if (bus.done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    check("burst2_rises", rises, 2);
    check("burst2_done_cycle", done_cyc, 9);
    check("burst2_done_count", done_n, 1);

    // reprogram during a high phase
    do_reset(1);
    step(0, 0, 0, 1, 1, 0);
    idle(1);
    step(1, 3, 1, 0, 0, 0);
    idle(12);

    // stop in first high cycle
    do_reset(1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(6);

    // zero lengths clamp to one; empty burst
    do_reset(1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    idle(6);
    do_reset(1);
    step(0, 0, 0, 1, 2, 0);
    check("burst0_done", bus.done, 1);
    idle(1);
    check("burst0_done_clear", bus.done, 0);

    // reset mid-burst, then defaults again
    do_reset(1);
    step(0, 0, 0, 1, 2, 5);
    idle(1);
    do_reset(1);
    check("abort_clk_out", bus.clk_out, 0);
    step(0, 0, 0, 1, 1, 0);
    idle(6);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299) == 0) do_reset(1);
      else step($urandom_range(7) == 0, $urandom_range(4), $urandom_range(4),
                $urandom_range(9) == 0, $urandom_range(3), $urandom_range(3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clock_burst_sequencer.md
Name: clock_burst_sequencer

Overview:
Run-time controller for a divided clock output.
- Generates clk_out from clk_in with high and low phase lengths that can be reprogrammed while running. Phase lengths are counted in clk_in cycles.
- Sequences the output through free-run, N-pulse burst and graceful-stop operations.
- Never truncates a high or low phase, so the output is glitch-free.
- Sits between the system control logic and any logic clocked or strobed by the divided clock.

Parameters:
- REGISTER_WIDTH, 8: width of the phase-length and phase-counter registers.
- BURST_WIDTH, 16: width of the burst pulse count.
- DEFAULT_UP, 2: high-phase length after reset, in clk_in cycles.
- DEFAULT_DOWN, 2: low-phase length after reset, in clk_in cycles.

Ports:
- clk_in  input  1  source clock
- reset  input  1  synchronous, active-high reset
- cfg_valid  input  1  new phase lengths offered
- cfg_ready  output  1  shadow config register empty
- cfg_up  input  REGISTER_WIDTH  high-phase length
- cfg_down  input  REGISTER_WIDTH  low-phase length
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command can be accepted
- cmd_op  input  2  0=STOP, 1=RUN, 2=BURST, 3=reserved
- cmd_count  input  BURST_WIDTH  pulse count for BURST
- clk_out  output  1  divided clock, registered
- busy  output  1  state is not IDLE
- done  output  1  one-cycle strobe on return to IDLE

Behaviour:
Interface:
- Clock clk_in, all logic on its rising edge.
- reset is synchronous, active-high.

Reset values:
- Outputs: clk_out=0, busy=0, done=0, cfg_ready=1, cmd_ready=1.
- Internal: state=IDLE, active_up=DEFAULT_UP, active_down=DEFAULT_DOWN, shadow config empty, burst remaining=0.
- Reset asserted mid-operation aborts immediately: clk_out is 0 the next cycle, pending config is discarded, done is not pulsed.

Handshakes:
- Transfer occurs when valid && ready on a clock edge.
- cfg_up or cfg_down equal to 0 is clamped to 1.

Config handling:
- In IDLE, accepted cfg is written straight into active_up/active_down.
- In any other state, accepted cfg goes to a one-deep shadow register and cfg_ready drops.
- The shadow is copied to active on the next low-to-high transition of clk_out. That high phase already uses the new up length. cfg_ready rises the following cycle.

Commands:
- cmd_ready=1 in IDLE and RUN, 0 in BURST and STOPPING.
- cmd_op=3 is accepted and ignored.

States:
- IDLE: clk_out=0.
  - RUN → RUN state.
  - BURST with count>0 → BURST state.
  - BURST with count=0 → no output pulses; done pulses the next cycle.
  - STOP → no-op.
  - If cfg and cmd are accepted on the same edge, the new cfg applies to the first period.
  - The first high phase begins the cycle after acceptance (latency 1).
- RUN: free-running.
  - clk_out is high for exactly active_up cycles, then low for exactly active_down cycles.
  - Phase counter runs from 1 up to the active length, then reloads to 1 on each transition.
  - STOP → STOPPING.
  - BURST N → BURST state with remaining=N. Only high phases that begin after acceptance are counted.
  - RUN → no-op.
- BURST:
  - remaining decrements at the end of each low phase.
  - When remaining reaches 0, go to IDLE with no further high phase. done=1 on that IDLE cycle.
- STOPPING: completes the current period, i.e. any remaining high phase plus the full low phase. Then IDLE with done=1.

Invariants:
- After leaving IDLE, every high phase and every low phase has its full programmed length.
- The minimum low time before re-entering a high phase is active_down.

Output signals:
- busy = (state != IDLE), registered with state.
- done is asserted only on the first IDLE cycle after BURST or STOPPING.

Widths:
- Phase counters are REGISTER_WIDTH bits; no wrap is possible because the compare limit is at most 2^REGISTER_WIDTH−1.
- remaining is BURST_WIDTH bits and never decrements below 0.

Decomposition:
- Package clock_seq_pkg:
  - cmd_op_e enum: STOP, RUN, BURST, RSVD.
  - seq_state_e enum: IDLE, RUN, BURST, STOPPING.
  - Op-code constants.
- Sub-module clock_phase_counter, holding the phase counter, clk_out register and phase compare.
  - Inputs: enable, up_len, down_len, load_start.
  - Outputs: clk_out, rise_strobe, fall_end_strobe (end of low phase).
- The top level holds the FSM, shadow config and burst counter.

Test Plan:
1. Reset, then RUN accepted at cycle 0 with default 2/2 → clk_out high cycles 1-2, low 3-4, high 5-6, repeating; busy=1 from cycle 1.
2. IDLE, BURST count=2 at cycle 0 with 2/2 → high 1-2, low 3-4, high 5-6, low 7-8; done=1 at cycle 9 only; busy=0 from cycle 9; exactly 2 rising edges.
3. RUN 2/2, cfg up=3 down=1 accepted during a high phase → current period finishes as 2/2; next high lasts 3 and low lasts 1; cfg_ready low until the cycle after that rise.
4. RUN, STOP accepted in the 1st high cycle → high completes (2 cycles), low completes (2 cycles), then IDLE with done pulse; cmd_ready=0 throughout STOPPING.
5. cfg up=0 down=0 in IDLE, then RUN → clk_out toggles every cycle (clamped to 1/1); BURST count=0 → no pulses, done the next cycle.
6. Reset asserted mid-high during BURST with remaining=5 → clk_out=0, busy=0, done=0 the next cycle; a later RUN uses DEFAULT_UP/DEFAULT_DOWN.
